vdp_port_ctrl: RTL

- CPU-side VDP port controller. Decodes control-port and data-port accesses into VDP register writes, VRAM port-A reads/writes and CRAM writes.
- Owns the 14-bit VRAM address register, the command code, the two-byte latch flag and the read-ahead buffer.
- Replaces the UART loader as the sole master of VRAM port A. The vdp_background path keeps port B.

---
 rtl/vdp_pkg.sv | 29 ++
 rtl/vdp_port_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU-port controller.
//   - command codes latched from the second control-port byte
//   - prefetch / CRAM-pair FSM states
//   - VRAM and CRAM address widths, plus the wrapping VRAM address increment
package vdp_pkg;

  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned CRAM_AW = 6;

  typedef enum logic [1:0] {
    CODE_VRAM_RD = 2'd0,
    CODE_VRAM_WR = 2'd1,
    CODE_REG_WR  = 2'd2,
    CODE_CRAM_WR = 2'd3
  } code_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_ADDR = 2'd1,
    S_RD_CAP  = 2'd2,
    S_CRAM2   = 2'd3
  } state_e;

  // 14-bit modulo increment: 3FFF wraps to 0000.
  function automatic logic [VRAM_AW-1:0] addr_inc(input logic [VRAM_AW-1:0] a);
    return a + VRAM_AW'(1);
  endfunction

endpackage

// File: rtl/vdp_port_ctrl.sv
// CPU-side VDP port controller. Decodes control/data port accesses into VDP register
// writes, VRAM port-A reads/writes and CRAM writes; sole master of VRAM port A.
//
// Ports:
//   vga_clk, rst                      clock, asynchronous active-high reset
//   cpu_wr_ctrl/cpu_wr_data           one-cycle write strobes carrying cpu_di
//   cpu_rd_ctrl/cpu_rd_data           one-cycle read strobes (status / data)
//   cpu_do                            registered read data, valid the cycle after a read
//   busy, overrun                     FSM activity; sticky flag for dropped strobes
//   status_in, status_rd              VDP status byte in; pulse on a status read
//   vram_addr/we/di, vram_do          VRAM port A (1-cycle synchronous read latency)
//   reg_we/addr/data                  VDP register write
//   cram_we/addr/di                   CRAM byte write
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 11,
  parameter bit          CRAM_PAIR = 1'b1
) (
  input  logic               vga_clk,
  input  logic               rst,
  input  logic               cpu_wr_ctrl,
  input  logic               cpu_wr_data,
  input  logic               cpu_rd_ctrl,
  input  logic               cpu_rd_data,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  output logic               busy,
  output logic               overrun,
  input  logic [7:0]         status_in,
  output logic               status_rd,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_di,
  input  logic [7:0]         vram_do,
  output logic               reg_we,
  output logic [3:0]         reg_addr,
  output logic [7:0]         reg_data,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]         cram_di
);

  state_e             state_q, state_d;
  code_e              code_q, code_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic               first_done_q, first_done_d;
  logic [7:0]         latch_q, latch_d;
  logic [7:0]         read_buf_q, read_buf_d;
  logic [7:0]         cram_lo_q, cram_lo_d;
  logic [7:0]         cram_hi_q, cram_hi_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         cpu_do_q, cpu_do_d;
  logic               status_rd_q, status_rd_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic               vram_we_q, vram_we_d;
  logic [7:0]         vram_di_q, vram_di_d;
  logic               reg_we_q, reg_we_d;
  logic [3:0]         reg_addr_q, reg_addr_d;
  logic [7:0]         reg_data_q, reg_data_d;
  logic               cram_we_q, cram_we_d;
  logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
  logic [7:0]         cram_di_q, cram_di_d;

  logic               any_strobe, multi_strobe;
  logic               acc_wr_ctrl, acc_wr_data, acc_rd_data, acc_rd_ctrl;
  logic               start_rd;
  logic [VRAM_AW-1:0] rd_addr;
  code_e              new_code;

  assign any_strobe   = cpu_wr_ctrl | cpu_wr_data | cpu_rd_ctrl | cpu_rd_data;
  assign multi_strobe = (cpu_wr_ctrl & (cpu_wr_data | cpu_rd_data | cpu_rd_ctrl)) |
                        (cpu_wr_data & (cpu_rd_data | cpu_rd_ctrl)) |
                        (cpu_rd_data & cpu_rd_ctrl);

  // Priority wr_ctrl > wr_data > rd_data > rd_ctrl; nothing is accepted while busy.
  assign acc_wr_ctrl = ~busy_q & cpu_wr_ctrl;
  assign acc_wr_data = ~busy_q & ~cpu_wr_ctrl & cpu_wr_data;
  assign acc_rd_data = ~busy_q & ~cpu_wr_ctrl & ~cpu_wr_data & cpu_rd_data;
  assign acc_rd_ctrl = ~busy_q & ~cpu_wr_ctrl & ~cpu_wr_data & ~cpu_rd_data & cpu_rd_ctrl;

  assign new_code = code_e'(cpu_di[7:6]);

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    addr_d       = addr_q;
    first_done_d = first_done_q;
    latch_d      = latch_q;
    read_buf_d   = read_buf_q;
    cram_lo_d    = cram_lo_q;
    cram_hi_d    = cram_hi_q;
    cpu_do_d     = cpu_do_q;
    vram_addr_d  = vram_addr_q;
    vram_di_d    = vram_di_q;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    cram_addr_d  = cram_addr_q;
    cram_di_d    = cram_di_q;
    vram_we_d    = 1'b0;
    reg_we_d     = 1'b0;
    cram_we_d    = 1'b0;
    status_rd_d  = 1'b0;
    start_rd     = 1'b0;
    rd_addr      = addr_q;
    overrun_d    = overrun_q | multi_strobe | (busy_q & any_strobe);

    unique case (state_q)
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        read_buf_d = vram_do;
        state_d    = S_IDLE;
      end
      S_CRAM2: begin
        // Second half of the Game Gear pair: the odd byte captured on the strobe.
        cram_we_d   = 1'b1;
        cram_addr_d = {addr_q[CRAM_AW-1:1], 1'b1};
        cram_di_d   = cram_hi_q;
        addr_d      = addr_inc(addr_q);
        state_d     = S_IDLE;
      end
      default: begin
        if (acc_wr_ctrl) begin
          if (!first_done_q) begin
            latch_d      = cpu_di;
            addr_d       = {addr_q[VRAM_AW-1:8], cpu_di};
            first_done_d = 1'b1;
          end else begin
            code_d       = new_code;
            addr_d       = {cpu_di[5:0], addr_q[7:0]};
            first_done_d = 1'b0;
            unique case (new_code)
              CODE_VRAM_RD: begin
                start_rd = 1'b1;
                rd_addr  = {cpu_di[5:0], addr_q[7:0]};
              end
              CODE_REG_WR: begin
                if (32'(cpu_di[3:0]) < NUM_REGS) begin
                  reg_we_d   = 1'b1;
                  reg_addr_d = cpu_di[3:0];
                  reg_data_d = latch_q;
                end
              end
              default: ;
            endcase
          end
        end else if (acc_wr_data) begin
          first_done_d = 1'b0;
          if (code_q != CODE_CRAM_WR) begin
            vram_we_d   = 1'b1;
            vram_addr_d = addr_q;
            vram_di_d   = cpu_di;
            read_buf_d  = cpu_di;
            addr_d      = addr_inc(addr_q);
          end else if (!CRAM_PAIR) begin
            cram_we_d   = 1'b1;
            cram_addr_d = addr_q[CRAM_AW-1:0];
            cram_di_d   = cpu_di;
            addr_d      = addr_inc(addr_q);
          end else if (!addr_q[0]) begin
            cram_lo_d = cpu_di;
            addr_d    = addr_inc(addr_q);
          end else begin
            // Even byte goes out now; odd byte is held and written next cycle.
            cram_we_d   = 1'b1;
            cram_addr_d = {addr_q[CRAM_AW-1:1], 1'b0};
            cram_di_d   = cram_lo_q;
            cram_hi_d   = cpu_di;
            state_d     = S_CRAM2;
          end
        end else if (acc_rd_data) begin
          cpu_do_d     = read_buf_q;
          first_done_d = 1'b0;
          start_rd     = 1'b1;
          rd_addr      = addr_q;
        end else if (acc_rd_ctrl) begin
          cpu_do_d     = status_in;
          status_rd_d  = 1'b1;
          first_done_d = 1'b0;
        end
      end
    endcase

    if (start_rd) begin
      vram_addr_d = rd_addr;
      addr_d      = addr_inc(rd_addr);
      state_d     = S_RD_ADDR;
    end

    // Busy also covers the cycle in which the last FSM action lands on the outputs
    // (read_buf capture or the second CRAM byte).
    busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= CODE_VRAM_RD;
      addr_q       <= '0;
      first_done_q <= 1'b0;
      latch_q      <= '0;
      read_buf_q   <= '0;
      cram_lo_q    <= '0;
      cram_hi_q    <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      cpu_do_q     <= '0;
      status_rd_q  <= 1'b0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_di_q    <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= '0;
      cram_di_q    <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      addr_q       <= addr_d;
      first_done_q <= first_done_d;
      latch_q      <= latch_d;
      read_buf_q   <= read_buf_d;
      cram_lo_q    <= cram_lo_d;
      cram_hi_q    <= cram_hi_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      cpu_do_q     <= cpu_do_d;
      status_rd_q  <= status_rd_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_di_q    <= vram_di_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      cram_we_q    <= cram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_di_q    <= cram_di_d;
    end
  end

  assign cpu_do    = cpu_do_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign status_rd = status_rd_q;
  assign vram_addr = vram_addr_q;
  assign vram_we   = vram_we_q;
  assign vram_di   = vram_di_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign cram_we   = cram_we_q;
  assign cram_addr = cram_addr_q;
  assign cram_di   = cram_di_q;

endmodule
